// File: rtl/nps_rom.sv
// Two-stage pipelined lookup ROM holding word[a] = a*a (mod 2^DATA_WIDTH),
// with a frame-end flag carried alongside the read data.
module nps_rom #(
    parameter int DATA_WIDTH = 24,
    parameter int ADR_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  start,
    input  logic                  set,
    input  logic                  vi,
    input  logic                  fi,
    input  logic [ADR_WIDTH-1:0]  datai,
    output logic                  vo,
    output logic                  fo,
    output logic [DATA_WIDTH-1:0] datao
);

    localparam int DEPTH = 2 ** ADR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] square_word(input int unsigned a);
        return DATA_WIDTH'(64'(a) * 64'(a));
    endfunction

    // NOTE: the ROM is constant contents, not state, so it has no reset; only the pipeline registers do.
    logic [DATA_WIDTH-1:0] rom [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = square_word(a);
    end

    logic [ADR_WIDTH-1:0] addr_s1;
    logic                 vi_s1;
    logic                 fi_s1;

    // NOTE: every register below uses <= so both stages update from pre-edge values.
    always_ff @(posedge clk or posedge reset_x) begin
        if (reset_x) begin
            addr_s1 <= '0;
            vi_s1   <= 1'b0;
            fi_s1   <= 1'b0;
            vo      <= 1'b0;
            fo      <= 1'b0;
            datao   <= '0;
        end else if (set) begin
            addr_s1 <= '0;
            vi_s1   <= 1'b0;
            fi_s1   <= 1'b0;
            vo      <= 1'b0;
            fo      <= 1'b0;
            datao   <= '0;
        end else begin
            vi_s1 <= vi;
            if (vi) begin
                addr_s1 <= datai;
            end
            vo <= vi_s1;
            // datao holds between reads so idle cycles never show stale-looking new data
            if (vi_s1) begin
                datao <= rom[addr_s1];
            end
            // start flushes only the frame-end flag; reads in flight are untouched
            fi_s1 <= start ? 1'b0 : fi;
            fo    <= start ? 1'b0 : fi_s1;
        end
    end

endmodule

// File: tb/tb_nps_rom.sv
// Scoreboard bench for nps_rom: stimulus pushes expected reads into a queue,
// a negedge monitor pops and compares them along with fo and the held datao.
module tb_nps_rom;

    localparam int DW        = 24;
    localparam int AW        = 9;
    localparam int MAX_CYC   = 8192;

    logic          clk = 1'b0;
    logic          reset_x = 1'b0;
    logic          start = 1'b0;
    logic          set = 1'b0;
    logic          vi = 1'b0;
    logic          fi = 1'b0;
    logic [AW-1:0] datai = '0;
    logic          vo;
    logic          fo;
    logic [DW-1:0] datao;

    nps_rom #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_x (reset_x),
        .start   (start),
        .set     (set),
        .vi      (vi),
        .fi      (fi),
        .datai   (datai),
        .vo      (vo),
        .fo      (fo),
        .datao   (datao)
    );

    always #5 clk = ~clk;

    // Cycle m is the interval after the m-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];
    bit   fi_h  [MAX_CYC];
    bit   st_h  [MAX_CYC];
    bit   clr_h [MAX_CYC];

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] ref_word(input int a);
        longint p;
        p = (longint'(a) * longint'(a)) % (longint'(1) << DW);
        return p[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Discard every expected read due in cycle e or later.
    task automatic drop_from(input int e);
        while (q.size() > 0 && q[$].due >= e) void'(q.pop_back());
    endtask

    // Present one cycle of inputs (called 2 time units after a rising edge).
    task automatic drive(input bit v, input logic [AW-1:0] a, input bit f,
                         input bit st, input bit s);
        vi = v; datai = a; fi = f; start = st; set = s;
        fi_h[cyc] = f;
        st_h[cyc] = st;
        if (s) begin
            clr_h[cyc] = 1'b1;
            drop_from(cyc + 1);
        end else if (v) begin
            q.push_back('{data: ref_word(int'(a)), due: cyc + 2});
        end
        @(posedge clk); #2;
    endtask

    // Hold reset for n cycles with vi=1 presented; outputs must clear at once.
    task automatic do_reset(input int n);
        reset_x = 1'b1;
        vi = 1'b1; datai = AW'($urandom); fi = $urandom_range(0, 1) != 0;
        start = 1'b0; set = 1'b0;
        if (cyc > 0) clr_h[cyc - 1] = 1'b1;
        clr_h[cyc] = 1'b1;
        drop_from(cyc);
        #1;
        check("async_reset_vo", {31'd0, vo}, 32'd0);
        check("async_reset_fo", {31'd0, fo}, 32'd0);
        check("async_reset_datao", {8'd0, datao}, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            datai = AW'($urandom);
            if (i != n - 1) clr_h[cyc] = 1'b1;
        end
        reset_x = 1'b0;
    endtask

    // Monitor: compares outputs every cycle against the scoreboard.
    logic [DW-1:0] exp_hold = '0;
    bit            exp_v;
    bit            exp_fo;
    exp_t          ent;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAX_CYC) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                ent = q.pop_front();
                check("lost_read", 32'(ent.due), 32'(cyc));
            end
            if (clr_h[cyc - 1]) exp_hold = '0;
            exp_v = q.size() > 0 && q[0].due == cyc;
            if (exp_v) begin
                ent = q.pop_front();
                exp_hold = ent.data;
            end
            check("vo", {31'd0, vo}, {31'd0, exp_v});
            check("datao", {8'd0, datao}, {8'd0, exp_hold});
            exp_fo = cyc >= 2 && fi_h[cyc - 2]
                     && !clr_h[cyc - 2] && !clr_h[cyc - 1]
                     && !st_h[cyc - 2] && !st_h[cyc - 1];
            check("fo", {31'd0, fo}, {31'd0, exp_fo});
        end
    end

    initial begin
        bit f_lvl;
        @(posedge clk); #2;

        // Reset held 3 cycles with vi=1, then the full address sweep.
        do_reset(3);
        for (int a = 0; a < 2 ** AW; a++) drive(1'b1, AW'(a), 1'b0, 1'b0, 1'b0);

        // Frame end after the sweep: fi alone, vo stays 0.
        for (int i = 0; i < 4; i++) drive(1'b0, AW'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, AW'($urandom), 1'b0, 1'b0, 1'b0);

        // Gapped stream 3, x, 10.
        drive(1'b1, AW'(3), 1'b0, 1'b0, 1'b0);
        drive(1'b0, AW'($urandom), 1'b0, 1'b0, 1'b0);
        drive(1'b1, AW'(10), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, AW'($urandom), 1'b0, 1'b0, 1'b0);

        // Clear one cycle after issuing address 7.
        drive(1'b1, AW'(5), 1'b0, 1'b0, 1'b0);
        drive(1'b1, AW'(7), 1'b0, 1'b0, 1'b0);
        drive(1'b1, AW'(9), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, AW'($urandom), 1'b0, 1'b0, 1'b0);

        // Start pulse while fi is held high.
        for (int i = 0; i < 8; i++) drive(1'b0, AW'($urandom), 1'b1, i == 3, 1'b0);

        // vi and fi together, then the top address.
        drive(1'b1, AW'(16), 1'b1, 1'b0, 1'b0);
        drive(1'b1, '1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, AW'($urandom), 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional start, set and mid-stream reset.
        f_lvl = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) f_lvl = ~f_lvl;
            if ($urandom_range(0, 149) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                drive($urandom_range(0, 3) != 0, AW'($urandom), f_lvl,
                      $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
            end
        end

        // Explicit mid-stream reset with reads in flight.
        drive(1'b1, AW'(100), 1'b1, 1'b0, 1'b0);
        drive(1'b1, AW'(200), 1'b1, 1'b0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1'b0, AW'($urandom), 1'b0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
